// File: rtl/tuple_pkg.sv
// Shared types for the generated-tuple receive path: tuple/row shapes,
// geometry constants and the scan FSM state encoding.
package tuple_pkg;

    typedef logic [4:2][1:0][2:2][0:2] tuple_t;
    typedef logic [0:2]                row_t;

    localparam int NUM_ROWS   = 6;
    localparam int TUPLE_BITS = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage : tuple_pkg

// File: rtl/tuple_scan_rx_row_classify.sv
// Combinational classifier for one 3-bit row: counts exact ones, exact
// zeros and anything else (X or Z) and flags a row holding any unknown.
module row_classify
    import tuple_pkg::*;
(
    input  row_t       row,
    output logic [1:0] ones,
    output logic [1:0] zeros,
    output logic [1:0] unk,
    output logic       any_unk
);

    // Four-state exact classification; X and Z both land in unk.
    always_comb begin
        ones    = 2'd0;
        zeros   = 2'd0;
        unk     = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (row[k] === 1'b1) begin
                ones = ones + 2'd1;
            end else if (row[k] === 1'b0) begin
                zeros = zeros + 2'd1;
            end else begin
                unk = unk + 2'd1;
            end
        end
        any_unk = (unk != 2'd0);
    end

endmodule : row_classify

// File: rtl/tuple_scan_rx.sv
// Receives one tuple per handshake, scans it a row per cycle from row 5
// down to row 0, and presents bit-class counts plus a word compare.
module tuple_scan_rx
    import tuple_pkg::*;
#(
    parameter int signed EXPECT_WORD = 32'sd13,
    parameter int        ROW_W       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:2][1:0][2:2][0:2]  in_tuple,
    input  logic signed [31:0]         in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 ones_cnt,
    output logic [4:0]                 zeros_cnt,
    output logic [4:0]                 unk_cnt,
    output logic [5:0]                 row_unk,
    output logic                       word_mismatch,
    output logic signed [31:0]         word_echo
);

    scan_state_e state_r;
    tuple_t      tuple_r;
    logic [2:0]  ptr_r;

    logic [TUPLE_BITS-1:0] flat_s;
    logic [4:0]            base_s;
    row_t                  row_s;
    logic [1:0]            row_ones_s;
    logic [1:0]            row_zeros_s;
    logic [1:0]            row_unk_s;
    logic                  row_any_unk_s;

    // Row r sits at flat bits [r*ROW_W +: ROW_W], with element [0] as the MSB.
    always_comb begin
        flat_s = tuple_r;
        base_s = 5'(ptr_r) * 5'(ROW_W);
        row_s  = flat_s[base_s +: 3];
    end

    row_classify u_row_classify (
        .row     (row_s),
        .ones    (row_ones_s),
        .zeros   (row_zeros_s),
        .unk     (row_unk_s),
        .any_unk (row_any_unk_s)
    );

    // Scan FSM with capture registers, row pointer and result accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            tuple_r       <= '0;
            ptr_r         <= 3'd0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            ones_cnt      <= 5'd0;
            zeros_cnt     <= 5'd0;
            unk_cnt       <= 5'd0;
            row_unk       <= 6'd0;
            word_mismatch <= 1'b0;
            word_echo     <= 32'sd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        tuple_r       <= in_tuple;
                        word_echo     <= in_word;
                        // Two-state compare: an unknown word bit reads as 0.
                        word_mismatch <= (int'(in_word) != EXPECT_WORD);
                        ones_cnt      <= 5'd0;
                        zeros_cnt     <= 5'd0;
                        unk_cnt       <= 5'd0;
                        row_unk       <= 6'd0;
                        ptr_r         <= 3'd5;
                        in_ready      <= 1'b0;
                        state_r       <= SCAN;
                    end
                end
                SCAN: begin
                    ones_cnt  <= ones_cnt  + {3'd0, row_ones_s};
                    zeros_cnt <= zeros_cnt + {3'd0, row_zeros_s};
                    unk_cnt   <= unk_cnt   + {3'd0, row_unk_s};
                    row_unk   <= row_unk | (6'(row_any_unk_s) << ptr_r);
                    if (ptr_r == 3'd0) begin
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        ptr_r <= ptr_r - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule : tuple_scan_rx
